seq_detect_fsm: RTL and testbench
=================================

// Module: seq_detect_fsm
// PURPOSE
//  Parametrised serial sequence detector; successor to the fixed Mealy/Moore pair.
//  Detects an N-bit PATTERN on serial input X, MSB received first.
//  Output style is selectable: Mealy (combinational) or Moore (registered).
//  Overlap mode is selectable. Adds an input-enable and a saturating detection counter.
//  Sits after the serial receive stage; Q feeds event logic, match_count feeds status readback.
// PARAMETERS
//  N        4        pattern length in bits, 2..16
//  PATTERN  4'b1011  bit pattern; PATTERN[N-1] is the first bit expected
//  MEALY    1        1 = Mealy output, 0 = Moore output
//  OVERLAP  1        1 = overlapping matches allowed, 0 = restart from empty after each match
//  CNT_W    8        width of match_count
// PORTS
//  clk          in   1      clock, all state on rising edge
//  reset        in   1      synchronous, active-high reset
//  en           in   1      1 = X is sampled this cycle; 0 = hold state
//  X            in   1      serial data bit
//  cnt_clr      in   1      synchronous clear of match_count
//  Q            out  1      detection flag
//  match_count  out  CNT_W  number of detections, saturating
// BEHAVIOUR
//  State encoding
//   - State k = number of pattern bits currently matched, i.e. the longest prefix of
//     PATTERN that is a suffix of the accepted bits.
//   - Mealy states: 0..N-1. Moore states: 0..N; state N means "match just completed".
//  Transition on a sampled bit (en=1) from state k<N
//   - X==PATTERN[N-1-k]: go to k+1.
//   - Otherwise: KMP fallback to the longest prefix that is a suffix of (matched prefix, X).
//     The fallback may be 0, or nonzero (e.g. 1011: state 2 "10" + X=0 -> state 0;
//     state 1 "1" + X=1 -> state 1).
//   - Fallback table is computed at elaboration from PATTERN. It is not hardcoded.
//  Match completion
//   - A match completes when k+1==N.
//   - Mealy: next state is F(N) if OVERLAP=1, else 0.
//     F(N) = longest proper prefix of PATTERN that is also its suffix.
//   - Moore: next state is N.
//  Leaving Moore state N (en=1)
//   - OVERLAP=1: transition is computed as from state F(N) with the new bit.
//   - OVERLAP=0: transition is computed as from state 0 with the new bit.
//   - A match may complete directly N->N.
//  Q
//   - Mealy: Q = en & (state==N-1) & (X==PATTERN[0]); combinational; 0 while reset=1.
//   - Moore: Q = (state==N); registered.
//   - Moore Q therefore equals Mealy Q delayed by one clock, given identical stimulus.
//  en=0
//   - State holds.
//   - Mealy Q=0.
//   - Moore Q holds its current value; state N persists.
//  match_count
//   - +1 on each clock edge where a match completes (en=1, state N-1, X==PATTERN[0]).
//     This is the same edge for both modes.
//   - Saturates at 2^CNT_W-1 (no wrap).
//   - cnt_clr=1 forces 0 and wins over a simultaneous match.
//  Reset
//   - reset=1 at a rising edge: state=0, match_count=0, Moore Q=0.
//   - Reset overrides en, X and cnt_clr.
//   - Mid-sequence reset discards any partial match.
// TESTING
//  1. Defaults; reset=1 for 2 clocks, then reset=0 -> Q=0, match_count=0.
//  2. en=1, X=1,0,1,1 -> Mealy Q=1 in the 4th-bit cycle only; Moore Q=1 the cycle after;
//     match_count=1.
//  3. X=1,0,1,1,0,1,1:
//     -> OVERLAP=1: two detections, match_count=2.
//     -> OVERLAP=0: one detection, match_count=1.
//  4. X=1,0, then en=0 for 3 clocks with X=0, then en=1 with X=1,1
//     -> detection on the final bit; no Q pulse while en=0.
//  5. CNT_W=2, five back-to-back 1011 patterns -> match_count=3 and holds.
//     cnt_clr asserted on the edge of a 6th match -> match_count=0.
//  6. X=1,0,1, reset for 1 clock, then X=1 -> no detection, match_count unchanged at 0.
//     Compare Mealy and Moore instances every cycle: Moore Q(t+1) == Mealy Q(t).

Source files
------------

// File: rtl/seq_detect_fsm.sv
// Parametrised serial pattern detector with selectable Mealy/Moore output,
// overlap handling, input enable and a saturating match counter.
module seq_detect_fsm #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter bit             MEALY   = 1'b1,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             X,
    input  logic             cnt_clr,
    output logic             Q,
    output logic [CNT_W-1:0] match_count
);

    // State k = number of pattern bits currently matched; N only in Moore.
    localparam int SW = $clog2(N + 1);
    localparam int TS = 1 << SW;

    typedef logic [SW-1:0] state_t;

    // Longest prefix of PATTERN that is a suffix of
    // (first k pattern bits, then bit x). Returns 0 for k >= N.
    function automatic int delta(int k, bit x);
        int best;
        int t;
        bit ok;
        bit sb;
        best = 0;
        if (k < N) begin
            for (int j = 1; j <= N; j++) begin
                if (j <= k + 1) begin
                    ok = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        if (i < j) begin
                            t = k + 1 - j + i;
                            if (t == k) sb = x;
                            else        sb = PATTERN[N-1-t];
                            if (sb != PATTERN[N-1-i]) ok = 1'b0;
                        end
                    end
                    if (ok) best = j;
                end
            end
        end
        return best;
    endfunction

    // Longest proper prefix of PATTERN that is also its suffix.
    function automatic int border();
        int best;
        bit ok;
        best = 0;
        for (int j = 1; j < N; j++) begin
            ok = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (i < j) begin
                    if (PATTERN[N-1-i] != PATTERN[j-1-i]) ok = 1'b0;
                end
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    localparam state_t S_ZERO    = '0;
    localparam state_t S_LAST    = state_t'(N - 1);
    localparam state_t S_FULL    = state_t'(N);
    localparam state_t S_BORDER  = state_t'(border());
    localparam state_t S_RESTART = OVERLAP ? S_BORDER : S_ZERO;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;
    state_t base;
    state_t step_nxt;
    logic   match;

    // Transition tables built at elaboration from PATTERN.
    state_t tab0 [TS];
    state_t tab1 [TS];

    for (genvar k = 0; k < TS; k++) begin : g_tab
        localparam state_t D0 = state_t'(delta(k, 1'b0));
        localparam state_t D1 = state_t'(delta(k, 1'b1));
        assign tab0[k] = D0;
        assign tab1[k] = D1;
    end

    // State register; reset discards any partial match.
    always_ff @(posedge clk) begin
        if (reset) state <= S_ZERO;
        else       state <= state_nxt;
    end

    // Next state: Moore state N behaves like the restart state for the new bit.
    always_comb begin
        base      = state;
        if (state == S_FULL) base = S_RESTART;
        step_nxt  = X ? tab1[base] : tab0[base];
        match     = en && (base == S_LAST) && (X == PATTERN[0]);
        state_nxt = state;
        if (en) begin
            state_nxt = step_nxt;
            if (match && MEALY) state_nxt = S_RESTART;
        end
    end

    if (MEALY) begin : g_mealy
        assign Q = match & ~reset;
    end else begin : g_moore
        assign Q = (state == S_FULL);
    end

    // Saturating detection counter; clear wins over a coincident match.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
        end else if (cnt_clr) begin
            match_count <= '0;
        end else if (match && (match_count != CNT_MAX)) begin
            match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: five configurations share one stimulus stream,
// checked against a shift-register reference model and a hand-derived table.
module tb_seq_detect_fsm;

    localparam int         N   = 4;
    localparam logic [3:0] PAT = 4'b1011;
    // instance i: 0 Mealy/ov, 1 Moore/ov, 2 Mealy/no-ov, 3 Moore/no-ov, 4 Mealy/ov/2-bit count
    localparam logic [4:0] OV    = 5'b10011;
    localparam logic [4:0] MOORE = 5'b01010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       X = 1'b0;
    logic       cnt_clr = 1'b0;
    logic [4:0] qv;
    logic [7:0] c0, c1, c2, c3;
    logic [1:0] c4;

    seq_detect_fsm #(.N(4), .PATTERN(4'b1011), .MEALY(1'b1), .OVERLAP(1'b1), .CNT_W(8)) u_me (
        .clk(clk), .reset(reset), .en(en), .X(X), .cnt_clr(cnt_clr), .Q(qv[0]), .match_count(c0));
    seq_detect_fsm #(.N(4), .PATTERN(4'b1011), .MEALY(1'b0), .OVERLAP(1'b1), .CNT_W(8)) u_mo (
        .clk(clk), .reset(reset), .en(en), .X(X), .cnt_clr(cnt_clr), .Q(qv[1]), .match_count(c1));
    seq_detect_fsm #(.N(4), .PATTERN(4'b1011), .MEALY(1'b1), .OVERLAP(1'b0), .CNT_W(8)) u_mn (
        .clk(clk), .reset(reset), .en(en), .X(X), .cnt_clr(cnt_clr), .Q(qv[2]), .match_count(c2));
    seq_detect_fsm #(.N(4), .PATTERN(4'b1011), .MEALY(1'b0), .OVERLAP(1'b0), .CNT_W(8)) u_on (
        .clk(clk), .reset(reset), .en(en), .X(X), .cnt_clr(cnt_clr), .Q(qv[3]), .match_count(c3));
    seq_detect_fsm #(.N(4), .PATTERN(4'b1011), .MEALY(1'b1), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .en(en), .X(X), .cnt_clr(cnt_clr), .Q(qv[4]), .match_count(c4));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [7:0] dut_c(input int i);
        case (i)
            0:       return c0;
            1:       return c1;
            2:       return c2;
            3:       return c3;
            4:       return {6'b0, c4};
            default: return 8'd0;
        endcase
    endfunction

    // Reference model: history of accepted bits since the last restart.
    logic [15:0] m_hist [5];
    int          m_len  [5];
    int          m_cnt  [5];
    logic        m_mq   [5];

    typedef struct packed {
        logic [4:0]      q;
        logic [4:0][7:0] c;
    } exp_t;

    exp_t sb[$];

    task automatic step(input logic r, input logic e, input logic xx, input logic cl,
                        output logic q0);
        exp_t       ex;
        logic [4:0] hit;
        int         cmax;
        reset   = r;
        en      = e;
        X       = xx;
        cnt_clr = cl;
        #1;
        for (int i = 0; i < 5; i++) begin
            hit[i] = !r && e && (m_len[i] >= N - 1) && ({m_hist[i][N-2:0], xx} == PAT);
            if (!MOORE[i]) check($sformatf("mealy_q[%0d]", i), 8'(qv[i]), 8'(hit[i]));
        end
        q0 = qv[0];
        for (int i = 0; i < 5; i++) begin
            cmax = (i == 4) ? 3 : 255;
            if (r) begin
                m_hist[i] = '0;
                m_len[i]  = 0;
                m_cnt[i]  = 0;
                m_mq[i]   = 1'b0;
            end else begin
                if (e) begin
                    m_hist[i] = {m_hist[i][14:0], xx};
                    m_len[i]++;
                    if (hit[i] && !OV[i]) m_len[i] = 0;
                    m_mq[i] = hit[i];
                end
                if (cl) m_cnt[i] = 0;
                else if (hit[i] && m_cnt[i] < cmax) m_cnt[i]++;
            end
            ex.q[i] = MOORE[i] ? m_mq[i] : 1'b0;
            ex.c[i] = m_cnt[i][7:0];
        end
        sb.push_back(ex);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 8'd1, 8'd0);
        end else begin
            ex = sb.pop_front();
            for (int i = 0; i < 5; i++) begin
                if (MOORE[i]) check($sformatf("moore_q[%0d]", i), 8'(qv[i]), 8'(ex.q[i]));
                check($sformatf("count[%0d]", i), dut_c(i), ex.c[i]);
            end
        end
        @(negedge clk);
    endtask

    // {reset, en, X, cnt_clr, expected Mealy/overlap Q} and its count after the edge
    typedef struct {
        logic [4:0] f;
        int         cnt;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [4:0] f, input int cnt);
        vec_t v;
        v.f   = f;
        v.cnt = cnt;
        tv.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       got;
        logic [3:0] pat_v;
        pat_v = PAT;
        for (int i = 0; i < 5; i++) begin
            m_hist[i] = '0;
            m_len[i]  = 0;
            m_cnt[i]  = 0;
            m_mq[i]   = 1'b0;
        end
        // reset, including reset overriding en/X
        add(5'b10000, 0); add(5'b11100, 0);
        // single 1011
        add(5'b01100, 0); add(5'b01000, 0); add(5'b01100, 0); add(5'b01101, 1);
        // 1011011 after reset: overlapping second hit
        add(5'b10000, 0);
        add(5'b01100, 0); add(5'b01000, 0); add(5'b01100, 0); add(5'b01101, 1);
        add(5'b01000, 1); add(5'b01100, 1); add(5'b01101, 2);
        // 1,0, stall, 1, stall on final bit, 1, then stall (Moore holds)
        add(5'b10000, 0);
        add(5'b01100, 0); add(5'b01000, 0);
        add(5'b00000, 0); add(5'b00000, 0); add(5'b00000, 0);
        add(5'b01100, 0); add(5'b00100, 0); add(5'b01101, 1);
        add(5'b00000, 1); add(5'b00000, 1);
        // 1,0,1 then reset with X=1, then 1
        add(5'b10000, 0);
        add(5'b01100, 0); add(5'b01000, 0); add(5'b01100, 0);
        add(5'b11100, 0); add(5'b01100, 0);

        @(negedge clk);
        foreach (tv[i]) begin
            step(tv[i].f[4], tv[i].f[3], tv[i].f[2], tv[i].f[1], got);
            check($sformatf("vec%0d_q", i), 8'(got), 8'(tv[i].f[0]));
            check($sformatf("vec%0d_cnt", i), c0, 8'(tv[i].cnt));
        end

        // five back-to-back patterns: 2-bit counter saturates at 3
        step(1'b1, 1'b0, 1'b0, 1'b0, got);
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 4; b++) step(1'b0, 1'b1, pat_v[3-b], 1'b0, got);
        end
        check("sat_hold", {6'b0, c4}, 8'd3);
        check("wide_five", c0, 8'd5);
        check("noov_five", c2, 8'd5);
        // sixth match with clear on the completing edge
        for (int b = 0; b < 3; b++) step(1'b0, 1'b1, pat_v[3-b], 1'b0, got);
        step(1'b0, 1'b1, pat_v[0], 1'b1, got);
        check("clr_mealy_q", 8'(got), 8'd1);
        check("clr_sat", {6'b0, c4}, 8'd0);
        check("clr_wide", c0, 8'd0);
        check("clr_moore_q", 8'(qv[1]), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
